// File: rtl/key_scan_pkg.sv
// Shared types and sizes for the keypad scan controller.
package key_scan_pkg;

  localparam int NUM_KEYS = 16;
  localparam int SEL_W    = 4;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Scan-step prescaler: counts 0..DIV_MAX while enabled and flags the last count.
module scan_prescaler #(
  parameter int DIV_MAX = 199
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_MAX);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: drives the decoder select, debounces the return line
// and hands out one key code per confirmed press over valid/ready.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int DIV_MAX = 199,
  parameter int DEB_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [SEL_W-1:0] sel,
  input  logic             key_in,
  output logic [SEL_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overflow
);

  localparam logic [3:0] DEB_L = 4'(DEB_CNT);

  logic             tick;
  logic             sync1_q, smp_q;
  scan_state_e      state_q;
  logic [SEL_W-1:0] sel_q, cand_q, code_q;
  logic [3:0]       cnt_q, rcnt_q;
  logic             valid_q, ovf_q;

  logic             confirm_d;
  logic [SEL_W-1:0] confirm_code_d;
  logic [3:0]       cnt_inc_d, rcnt_inc_d;

  scan_prescaler #(.DIV_MAX(DIV_MAX)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .tick_o(tick)
  );

  assign cnt_inc_d  = cnt_q + 4'd1;
  assign rcnt_inc_d = rcnt_q + 4'd1;

  // With DEB_CNT=1 the confirm happens on the detection tick, before cand is loaded.
  always_comb begin
    confirm_d      = 1'b0;
    confirm_code_d = cand_q;
    if (tick && smp_q) begin
      if (state_q == SCAN && DEB_CNT == 1) begin
        confirm_d      = 1'b1;
        confirm_code_d = sel_q;
      end else if (state_q == DEB && cnt_inc_d == DEB_L) begin
        confirm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      smp_q   <= 1'b0;
      state_q <= SCAN;
      sel_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= key_in;
      smp_q   <= sync1_q;

      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (smp_q) begin
              cand_q  <= sel_q;
              cnt_q   <= 4'd1;
              rcnt_q  <= '0;
              state_q <= (DEB_CNT == 1) ? HELD : DEB;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
          DEB: begin
            if (smp_q) begin
              cnt_q <= cnt_inc_d;
              if (cnt_inc_d == DEB_L) begin
                rcnt_q  <= '0;
                state_q <= HELD;
              end
            end else begin
              sel_q   <= cand_q + 1'b1;
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (smp_q) begin
              rcnt_q <= '0;
            end else if (rcnt_inc_d == DEB_L) begin
              rcnt_q  <= '0;
              sel_q   <= cand_q + 1'b1;
              state_q <= SCAN;
            end else begin
              rcnt_q <= rcnt_inc_d;
            end
          end
          default: state_q <= SCAN;
        endcase
      end

      ovf_q <= 1'b0;
      if (confirm_d) begin
        if (!valid_q || key_ready) begin
          code_q  <= confirm_code_d;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && key_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign sel       = sel_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overflow  = ovf_q;

endmodule
